// File: rtl/clock_set_ctrl.sv
// Time-set mode controller for the digital clock.
// Freezes the seconds counter, splits the captured time into h/m/s fields,
// lets the user step each field from debounced buttons while it blinks,
// then reloads the counter with the edited time.
//
// state   | meaning
// --------+-----------------------------------------------------------
// RUN     | counter advancing, waiting for a mode press
// CAPTURE | counter frozen, peeling hours/minutes off the captured time
// SET_H   | editing hours
// SET_M   | editing minutes
// SET_S   | editing seconds
// LOAD    | one-cycle load strobe to the counter, then back to RUN
module clock_set_ctrl #(
    parameter int DB_CYCLES   = 1000000,
    parameter int DAY_SECONDS = 86400
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_mode,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        onehz,
    input  logic [16:0] cur_seconds,
    output logic        run_en,
    output logic        load,
    output logic [16:0] load_seconds,
    output logic [4:0]  set_h,
    output logic [5:0]  set_m,
    output logic [5:0]  set_s,
    output logic [7:0]  digit_en
);

    localparam int              DB_W      = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_RELOAD = DB_W'(DB_CYCLES - 1);
    localparam logic [16:0]     DAY_LIMIT = 17'(DAY_SECONDS);

    typedef enum logic [2:0] {RUN, CAPTURE, SET_H, SET_M, SET_S, LOAD} state_t;

    // Button index: 0 = mode, 1 = up, 2 = down.
    logic [2:0]      btn_raw;
    logic [2:0]      sync1;
    logic [2:0]      sync2;
    logic [2:0]      db;
    logic [2:0]      db_d;
    logic [2:0]      press;
    logic [DB_W-1:0] db_cnt [3];

    logic oh_s1, oh_s2, oh_d, oh_rise;
    logic phase;

    state_t      state, state_next;
    logic [16:0] rem, rem_next;
    logic [4:0]  h_next;
    logic [5:0]  m_next, s_next;
    logic [16:0] ls_next;
    logic [16:0] total;

    assign btn_raw = {btn_down, btn_up, btn_mode};
    assign press   = db & ~db_d;
    assign oh_rise = oh_s2 & ~oh_d;
    assign total   = 17'(set_h) * 17'd3600 + 17'(set_m) * 17'd60 + 17'(set_s);

    // Synchronize the raw buttons; a down-counter sitting at its reload value
    // while the level agrees accepts a change after DB_CYCLES differing cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
            db    <= '0;
            db_d  <= '0;
            for (int i = 0; i < 3; i++) db_cnt[i] <= DB_RELOAD;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            db_d  <= db;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == db[i]) begin
                    db_cnt[i] <= DB_RELOAD;
                end else if (db_cnt[i] == '0) begin
                    db[i]     <= sync2[i];
                    db_cnt[i] <= DB_RELOAD;
                end else begin
                    db_cnt[i] <= db_cnt[i] - 1'b1;
                end
            end
        end
    end

    // Blink phase: toggles on 1 Hz rising edges, restarts visible on each field entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            oh_s1 <= 1'b0;
            oh_s2 <= 1'b0;
            oh_d  <= 1'b0;
            phase <= 1'b0;
        end else begin
            oh_s1 <= onehz;
            oh_s2 <= oh_s1;
            oh_d  <= oh_s2;
            if (state_next != state &&
                (state_next == SET_H || state_next == SET_M || state_next == SET_S))
                phase <= 1'b0;
            else if (oh_rise)
                phase <= ~phase;
        end
    end

    // State and edit-field registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= RUN;
            rem          <= '0;
            set_h        <= '0;
            set_m        <= '0;
            set_s        <= '0;
            load_seconds <= '0;
        end else begin
            state        <= state_next;
            rem          <= rem_next;
            set_h        <= h_next;
            set_m        <= m_next;
            set_s        <= s_next;
            load_seconds <= ls_next;
        end
    end

    // Next-state and field arithmetic; mode beats a same-cycle up/down.
    always_comb begin
        state_next = state;
        rem_next   = rem;
        h_next     = set_h;
        m_next     = set_m;
        s_next     = set_s;
        ls_next    = load_seconds;
        case (state)
            RUN: begin
                if (press[0]) begin
                    state_next = CAPTURE;
                    rem_next   = (cur_seconds >= DAY_LIMIT) ? '0 : cur_seconds;
                    h_next     = '0;
                    m_next     = '0;
                    s_next     = '0;
                end
            end
            CAPTURE: begin
                if (rem >= 17'd3600) begin
                    rem_next = rem - 17'd3600;
                    h_next   = set_h + 5'd1;
                end else if (rem >= 17'd60) begin
                    rem_next = rem - 17'd60;
                    m_next   = set_m + 6'd1;
                end else begin
                    s_next     = rem[5:0];
                    state_next = SET_H;
                end
            end
            SET_H: begin
                if (press[0])
                    state_next = SET_M;
                else if (press[1] && !press[2])
                    h_next = (set_h == 5'd23) ? 5'd0 : set_h + 5'd1;
                else if (press[2] && !press[1])
                    h_next = (set_h == 5'd0) ? 5'd23 : set_h - 5'd1;
            end
            SET_M: begin
                if (press[0])
                    state_next = SET_S;
                else if (press[1] && !press[2])
                    m_next = (set_m == 6'd59) ? 6'd0 : set_m + 6'd1;
                else if (press[2] && !press[1])
                    m_next = (set_m == 6'd0) ? 6'd59 : set_m - 6'd1;
            end
            SET_S: begin
                if (press[0]) begin
                    state_next = LOAD;
                    ls_next    = total;
                end else if (press[1] && !press[2]) begin
                    s_next = (set_s == 6'd59) ? 6'd0 : set_s + 6'd1;
                end else if (press[2] && !press[1]) begin
                    s_next = (set_s == 6'd0) ? 6'd59 : set_s - 6'd1;
                end
            end
            LOAD:    state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    // Counter control and blanking of the field under edit.
    always_comb begin
        run_en   = (state == RUN);
        load     = (state == LOAD);
        digit_en = 8'b1100_0000;
        if (phase) begin
            case (state)
                SET_H:   digit_en[5:4] = 2'b11;
                SET_M:   digit_en[3:2] = 2'b11;
                SET_S:   digit_en[1:0] = 2'b11;
                default: digit_en = 8'b1100_0000;
            endcase
        end
    end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: a field-level model predicts every output each
// cycle; directed button sequences walk capture, wrap, blink, load and reset.
module tb_clock_set_ctrl;

    localparam int DB  = 4;
    localparam int DAY = 86400;
    localparam int HD  = DB + 2;
    localparam int M_RUN  = 0;
    localparam int M_CAP  = 1;
    localparam int M_EDIT = 2;
    localparam int M_LOAD = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        btn_mode = 1'b0, btn_up = 1'b0, btn_down = 1'b0, onehz = 1'b0;
    logic [16:0] cur_seconds = '0;
    logic        run_en, load;
    logic [16:0] load_seconds;
    logic [4:0]  set_h;
    logic [5:0]  set_m, set_s;
    logic [7:0]  digit_en;

    int checks = 0;
    int errors = 0;
    int load_cnt = 0;

    clock_set_ctrl #(.DB_CYCLES(DB), .DAY_SECONDS(DAY)) dut (
        .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_up(btn_up),
        .btn_down(btn_down), .onehz(onehz), .cur_seconds(cur_seconds),
        .run_en(run_en), .load(load), .load_seconds(load_seconds),
        .set_h(set_h), .set_m(set_m), .set_s(set_s), .digit_en(digit_en)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit hb [3][0:HD-1];
    bit ohh [0:3];
    bit dbm [3];
    bit pend [3];
    bit pm [3];
    bit rawv [3];
    int mf [3];
    int tf [3];
    int m_mode, m_field, m_ls, cap_left, r;
    bit m_phase, entered, rise, same;

    function automatic int modv(input int f);
        return (f == 0) ? 24 : 60;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int b = 0; b < 3; b++) begin
                dbm[b] = 0; pend[b] = 0; mf[b] = 0; tf[b] = 0;
                for (int i = 0; i < HD; i++) hb[b][i] = 0;
            end
            for (int i = 0; i < 4; i++) ohh[i] = 0;
            m_mode = M_RUN; m_phase = 0; m_field = 0; m_ls = 0; cap_left = 0;
        end else begin
            rawv[0] = btn_mode; rawv[1] = btn_up; rawv[2] = btn_down;
            for (int b = 0; b < 3; b++) begin
                pm[b] = pend[b];
                for (int i = HD - 1; i > 0; i--) hb[b][i] = hb[b][i-1];
                hb[b][0] = rawv[b];
                // accepted once the synchronized level held DB samples against dbm
                same = 1;
                for (int i = 2; i < HD; i++) if (hb[b][i] != hb[b][2]) same = 0;
                pend[b] = 0;
                if (same && hb[b][2] != dbm[b]) begin
                    dbm[b]  = hb[b][2];
                    pend[b] = dbm[b];
                end
            end
            for (int i = 3; i > 0; i--) ohh[i] = ohh[i-1];
            ohh[0] = onehz;
            rise = ohh[2] & ~ohh[3];

            entered = 0;
            case (m_mode)
                M_RUN: if (pm[0]) begin
                    r = (int'(cur_seconds) >= DAY) ? 0 : int'(cur_seconds);
                    tf[0] = r / 3600;
                    tf[1] = (r % 3600) / 60;
                    tf[2] = r % 60;
                    cap_left = tf[0] + tf[1] + 1;
                    m_mode = M_CAP;
                end
                M_CAP: begin
                    cap_left--;
                    if (cap_left == 0) begin
                        for (int b = 0; b < 3; b++) mf[b] = tf[b];
                        m_mode = M_EDIT; m_field = 0; entered = 1;
                    end
                end
                M_EDIT: begin
                    if (pm[0]) begin
                        if (m_field < 2) begin
                            m_field++; entered = 1;
                        end else begin
                            m_mode = M_LOAD;
                            m_ls = mf[0] * 3600 + mf[1] * 60 + mf[2];
                        end
                    end else if (pm[1] && !pm[2]) begin
                        mf[m_field] = (mf[m_field] + 1) % modv(m_field);
                    end else if (pm[2] && !pm[1]) begin
                        mf[m_field] = (mf[m_field] + modv(m_field) - 1) % modv(m_field);
                    end
                end
                default: m_mode = M_RUN;
            endcase
            if (entered) m_phase = 0;
            else if (rise) m_phase = ~m_phase;
        end
    end

    // Per-cycle comparison against the model.
    always @(posedge clk) begin
        int exp_d;
        #1;
        if (rst) begin
            exp_d = 8'hC0;
            if (m_mode == M_EDIT && m_phase) exp_d = exp_d | (8'h30 >> (2 * m_field));
            check("run_en", int'(run_en), int'(m_mode == M_RUN));
            check("load", int'(load), int'(m_mode == M_LOAD));
            check("load_seconds", int'(load_seconds), m_ls);
            check("digit_en", int'(digit_en), exp_d);
            if (m_mode != M_CAP) begin
                check("set_h", int'(set_h), mf[0]);
                check("set_m", int'(set_m), mf[1]);
                check("set_s", int'(set_s), mf[2]);
            end
        end
    end

    always @(negedge clk) if (load) load_cnt++;

    // ---------------- stimulus ----------------
    task automatic drive_btn(input int b, input logic v);
        case (b)
            0: btn_mode = v;
            1: btn_up   = v;
            default: btn_down = v;
        endcase
    endtask

    task automatic press_btn(input int b);
        @(negedge clk);
        drive_btn(b, 1'b1);
        repeat (8) @(negedge clk);
        drive_btn(b, 1'b0);
        repeat (8) @(negedge clk);
    endtask

    task automatic press_n(input int b, input int n);
        for (int k = 0; k < n; k++) press_btn(b);
    endtask

    initial begin
        int t_fall, t_done, nload, lval, run_after, base;
        bit saw, got_after;

        repeat (3) @(negedge clk);
        check("rst_run_en", int'(run_en), 1);
        check("rst_load", int'(load), 0);
        check("rst_digit_en", int'(digit_en), 8'hC0);
        check("rst_load_seconds", int'(load_seconds), 0);
        rst = 1'b1;
        repeat (1000) @(negedge clk);
        check("idle_run_en", int'(run_en), 1);

        // short glitch must be rejected
        btn_mode = 1'b1;
        repeat (3) @(negedge clk);
        btn_mode = 1'b0;
        repeat (20) @(negedge clk);
        check("glitch_run_en", int'(run_en), 1);

        // capture 12:34:56
        cur_seconds = 17'd45296;
        t_fall = -1; t_done = -1;
        btn_mode = 1'b1;
        for (int t = 1; t <= 120; t++) begin
            @(negedge clk);
            if (t == 10) btn_mode = 1'b0;
            if (t_fall < 0 && !run_en) t_fall = t;
            if (t_fall >= 0 && set_s == 6'd56) begin
                t_done = t;
                break;
            end
        end
        check("press_latency", t_fall, 7);
        check("capture_cycles", t_done - t_fall, 47);
        check("cap_h", int'(set_h), 12);
        check("cap_m", int'(set_m), 34);
        check("cap_s", int'(set_s), 56);
        repeat (10) @(negedge clk);

        // hours wrap
        press_n(1, 11);
        check("h_to_23", int'(set_h), 23);
        press_btn(1);
        check("h_wrap_up", int'(set_h), 0);
        press_btn(2);
        check("h_wrap_down", int'(set_h), 23);

        // minutes: simultaneous up/down, then wraps
        press_btn(0);
        @(negedge clk);
        btn_up = 1'b1; btn_down = 1'b1;
        repeat (8) @(negedge clk);
        btn_up = 1'b0; btn_down = 1'b0;
        repeat (8) @(negedge clk);
        check("m_updown", int'(set_m), 34);
        press_n(1, 25);
        check("m_to_59", int'(set_m), 59);
        press_btn(1);
        check("m_wrap_up", int'(set_m), 0);
        press_btn(2);
        check("m_wrap_down", int'(set_m), 59);

        // blink in SET_M
        check("blink_entry", int'(digit_en), 8'hC0);
        onehz = 1'b1;
        repeat (5) @(negedge clk);
        check("blink_on", int'(digit_en), 8'hCC);
        onehz = 1'b0;
        repeat (5) @(negedge clk);
        check("blink_hold", int'(digit_en), 8'hCC);
        onehz = 1'b1;
        repeat (5) @(negedge clk);
        check("blink_off", int'(digit_en), 8'hC0);
        onehz = 1'b0;
        repeat (5) @(negedge clk);

        // seconds and load
        press_btn(0);
        press_n(1, 3);
        check("s_to_59", int'(set_s), 59);
        nload = 0; lval = -1; run_after = -1; saw = 0; got_after = 0;
        btn_mode = 1'b1;
        for (int t = 1; t <= 40; t++) begin
            @(negedge clk);
            if (t == 8) btn_mode = 1'b0;
            if (load) begin
                nload++;
                lval = int'(load_seconds);
                saw = 1;
            end else if (saw && !got_after) begin
                run_after = int'(run_en);
                got_after = 1;
            end
        end
        check("load_count", nload, 1);
        check("load_value", lval, 86399);
        check("run_after_load", run_after, 1);

        // out-of-range capture, then reset mid-SET_S
        cur_seconds = 17'd90000;
        press_btn(0);
        check("oor_h", int'(set_h), 0);
        check("oor_m", int'(set_m), 0);
        check("oor_s", int'(set_s), 0);
        check("oor_run_en", int'(run_en), 0);
        press_btn(0);
        press_btn(0);
        press_btn(1);
        check("pre_rst_s", int'(set_s), 1);
        base = load_cnt;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_run_en", int'(run_en), 1);
        check("midrst_load", int'(load), 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (30) @(negedge clk);
        check("post_rst_run_en", int'(run_en), 1);
        check("post_rst_loads", load_cnt - base, 0);
        check("post_rst_s", int'(set_s), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog actual timeout expected finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clock_set_ctrl.md
Name: clock_set_ctrl

Overview:
Mode controller for the digital clock. It freezes the seconds counter, captures the current time into editable hour/minute/second fields, and steps those fields from debounced buttons. It blinks the field being edited on the 8-digit display, then reloads the counter with the edited time. It sits between the board buttons, the 1 Hz generator, the seconds counter (run enable plus load port) and the display digit-enable input.

Parameters:
DB_CYCLES, 1000000, clk cycles a raw button level must be stable before it is accepted (10 ms at 100 MHz)
DAY_SECONDS, 86400, seconds per day; valid counter range is 0..DAY_SECONDS-1

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset
btn_mode  input  1  raw mode button, active-high, asynchronous to clk
btn_up  input  1  raw increment button, active-high, asynchronous
btn_down  input  1  raw decrement button, active-high, asynchronous
onehz  input  1  1 Hz square wave from the 1 Hz generator, used only for blink phase
cur_seconds  input  17  current seconds-of-day from the counter
run_en  output  1  counter advance enable
load  output  1  one-cycle strobe: counter takes load_seconds
load_seconds  output  17  value to load, h*3600 + m*60 + s
set_h  output  5  edited hours, binary 0..23
set_m  output  6  edited minutes, binary 0..59
set_s  output  6  edited seconds, binary 0..59
digit_en  output  8  active-low digit enables; [7:6] unused, [5:4] hours, [3:2] minutes, [1:0] seconds

Behaviour:
- Reset (rst=0, async):
  - state=RUN, run_en=1, load=0, load_seconds=0.
  - set_h/m/s=0, blink phase=0, digit_en=8'b11000000.
  - All synchronizer and debounce registers cleared.
- Button conditioning (each button independently):
  - 2-flop synchronizer, then debounce counter; the debounced level changes only after the synchronized level differs from it for DB_CYCLES consecutive cycles.
  - Debounced rising edge produces a 1-cycle press pulse. Press latency is 2+DB_CYCLES+1 cycles from the raw edge.
- States: RUN, CAPTURE, SET_H, SET_M, SET_S, LOAD.
- RUN:
  - run_en=1.
  - mode press -> CAPTURE: latch rem=cur_seconds and clear h/m/s; if cur_seconds>=DAY_SECONDS, latch rem=0.
  - up/down presses ignored.
- CAPTURE (run_en=0), one step per cycle:
  - If rem>=3600: rem-=3600, h++.
  - Else if rem>=60: rem-=60, m++.
  - Else: s=rem, go to SET_H.
  - Worst case 23+59+1 cycles.
  - All button presses arriving during CAPTURE are dropped.
- SET_H / SET_M / SET_S (run_en=0):
  - up press: selected field +1, wrapping 23->0 (hours) or 59->0.
  - down press: selected field -1, wrapping 0->23 or 0->59.
  - up and down pulses in the same cycle: no change.
  - mode press: SET_H->SET_M->SET_S->LOAD. A mode press takes priority over a same-cycle up/down (up/down ignored).
- LOAD:
  - Exactly one cycle: load=1, load_seconds=h*3600+m*60+s (computed combinationally from registers, registered onto the output this cycle).
  - run_en=0 during the LOAD cycle; next state RUN.
  - The counter must see load before run_en returns to 1.
- load_seconds holds its last loaded value outside LOAD.
- Blink:
  - Blink phase toggles on each rising edge of onehz (edge-detected with a 2-flop sync). Phase is forced to 0 on entry to each SET_x state.
  - In SET_x with phase=1, that field's two digit_en bits are 1 (blanked); all other digit bits [5:0] are 0.
  - In RUN, CAPTURE and LOAD, digit_en=8'b11000000.
- set_h/m/s:
  - Hold their value in RUN; the display mux uses them only in set modes.
  - Always within range; arithmetic never produces out-of-range values.
- Reset asserted mid-CAPTURE or mid-SET:
  - Returns immediately to RUN with run_en=1 and no load strobe.
  - The counter keeps its frozen value.

Test Plan:
- Reset release, no buttons -> run_en=1, load=0, digit_en=8'hC0, state RUN held for 1000 cycles.
- DB_CYCLES=4; btn_mode glitch high for 3 cycles -> no state change. Held 10 cycles -> one press; run_en falls within 8 cycles of the raw edge.
- cur_seconds=45296 (12:34:56), mode press -> after CAPTURE set_h=12, set_m=34, set_s=56; state SET_H; CAPTURE lasts 12+34+1=47 cycles.
- In SET_H at 23: up -> 0. Mode to SET_M at 0: down -> 59. Up+down in the same cycle -> unchanged.
- Edit to 23:59:59, three mode presses past SET_H -> exactly one load pulse with load_seconds=86399; run_en=1 on the following cycle.
- In SET_M, toggle onehz -> digit_en alternates 8'hC0 / 8'hCC; cur_seconds=90000 on capture -> fields 0:0:0; rst pulsed low mid-SET_S -> RUN, load never asserted.
